timer_irq_ctrl: RTL and testbench
=================================

// Module: timer_irq_ctrl
// PURPOSE
//   Interrupt controller downstream of the I/O timer(s): takes their pulse lines, detects
//   rising edges, latches them as pending requests and raises a single prioritised
//   interrupt to the monocycle CPU with an ack / end-of-interrupt handshake.
//   Also serves other I/O event sources; all sources are in the same clk domain.
// PARAMETERS
//   NSRC  4  number of event sources (1..8)
//   VW    2  vector width; must be >= clog2(NSRC) (VW=1 when NSRC=1)
// PORTS
//   clk        in   1     system clock, all state on posedge
//   reset      in   1     asynchronous, active-high; clears all state immediately
//   src        in   NSRC  event lines (e.g. timer pulse); rising edge = one event
//   mask_we    in   1     write strobe for mask register
//   mask_wdata in   NSRC  new mask value; bit=1 enables that source
//   ack        in   1     CPU accepts current request (1-cycle strobe)
//   eoi        in   1     CPU finished servicing (1-cycle strobe)
//   irq        out  1     interrupt request to CPU
//   vector     out  VW    index of source being requested/serviced
//   pending    out  NSRC  latched unserviced events (readable status)
//   in_service out  1     high while a request is acked and not yet ended
//   overrun    out  NSRC  sticky overrun flags (0 when IRQ_OVERRUN_EN is undefined)
// BEHAVIOUR
//   Reset: src_q, pending, mask, vector, overrun = 0; irq = 0; in_service = 0; state IDLE.
//   Edge detect: src_q <= src each cycle; edge = src & ~src_q. src_q resets to 0, so a
//     source already high after reset counts as one edge on the first clock.
//   Pending: bit set on edge regardless of mask; cleared only on ack for bit [vector].
//     Edge and ack-clear on the same bit in the same cycle -> bit stays set (event kept).
//   Mask: registered; mask_we loads mask_wdata, effective from the next cycle.
//     Masking a source does not clear its pending bit or cancel an irq already raised.
//   Eligible = pending & mask; priority: lowest index wins.
//   FSM (registered outputs):
//     IDLE : irq=0, in_service=0. If eligible!=0 -> REQ, vector <= lowest eligible index.
//     REQ  : irq=1, vector held stable. ack -> BUSY, clear pending[vector]. eoi ignored.
//     BUSY : irq=0, in_service=1, vector held. eoi -> IDLE. ack ignored.
//     ack in IDLE/BUSY and eoi in IDLE/REQ have no effect.
//     ack and eoi asserted together in REQ: ack taken, eoi ignored (stays BUSY).
//   Latency: rising src sampled at edge k -> pending visible after k; irq=1 after k+1
//     (IDLE, unmasked). After eoi at edge k, next irq at earliest after k+1.
//   No nesting: higher-priority edges arriving during REQ/BUSY only set pending; served
//     in priority order after eoi. vector is not re-evaluated while in REQ.
//   Reset asserted in REQ/BUSY: outputs drop to reset values asynchronously; in-flight
//     request lost.
// CONFIGURATION
//   IRQ_OVERRUN_EN defined: overrun[i] set when edge[i] occurs while pending[i] already
//     1 and not cleared that cycle; sticky, cleared only by reset or a mask_we
//     cycle with mask_wdata[i]=0.
//   Undefined: no overrun logic; overrun tied to 0; extra events silently merged.
// TESTING
//   1 NSRC=4, mask=4'b0001, src[0] 0->1 at edge k -> pending=0001 after k, irq=1,
//     vector=0 after k+1; ack -> irq=0, in_service=1, pending=0; eoi -> IDLE.
//   2 mask=4'b1111, src[3] and src[1] rise same cycle -> vector=1 first; after ack+eoi,
//     irq again with vector=3.
//   3 mask=0, src[2] rises -> pending=0100, irq stays 0; write mask=0100 -> irq=1 one
//     cycle after the write edge (vector=2).
//   4 src[0] edge in same cycle as ack of vector 0 -> pending[0] remains 1; after eoi
//     a second request for vector 0 is raised.
//   5 reset pulsed mid-REQ (async, between clock edges) -> irq, pending, mask and
//     in_service at 0 before next posedge.
//   6 IRQ_OVERRUN_EN defined: two src[1] edges before ack -> overrun=0010; undefined:
//     overrun=0 and one service only.

Source files
------------

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: edge-detects event lines, latches pending requests, raises one prioritised irq.
// Latency: src rise at edge k -> pending after k, irq after k+1; next irq >= 1 cycle after eoi edge.
// Backpressure: none; CPU paces service via ack/eoi, further events merge into pending bits.
// Optional feature: define IRQ_OVERRUN_EN for sticky per-source overrun flags.
module timer_irq_ctrl #(
    parameter int NSRC = 4,
    parameter int VW   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            ack,
    input  logic            eoi,
    output logic            irq,
    output logic [VW-1:0]   vector,
    output logic [NSRC-1:0] pending,
    output logic            in_service,
    output logic [NSRC-1:0] overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] edge_det;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] ack_clr;
    logic            take_ack;
    logic [VW-1:0]   lowest;
    logic [VW-1:0]   vector_nxt;
    logic            irq_nxt;
    logic            in_service_nxt;

    assign edge_det = src & ~src_q;
    assign eligible = pending & mask;
    assign take_ack = (state == REQ) && ack;
    // Only the bit currently being requested is cleared, and only when the CPU takes it.
    assign ack_clr  = take_ack ? (NSRC'(1) << vector) : '0;

    // Lowest eligible index wins; scanning downward leaves the smallest index last.
    always_comb begin
        lowest = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lowest = VW'(i);
            end
        end
    end

    // Next-state and next-output decode; vector only moves when leaving IDLE.
    always_comb begin
        state_nxt      = state;
        vector_nxt     = vector;
        irq_nxt        = 1'b0;
        in_service_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (eligible != '0) begin
                    state_nxt  = REQ;
                    vector_nxt = lowest;
                end
            end
            REQ: begin
                if (ack) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (eoi) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        irq_nxt        = (state_nxt == REQ);
        in_service_nxt = (state_nxt == BUSY);
    end

    // FSM state plus its registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vector     <= '0;
            irq        <= 1'b0;
            in_service <= 1'b0;
        end else begin
            state      <= state_nxt;
            vector     <= vector_nxt;
            irq        <= irq_nxt;
            in_service <= in_service_nxt;
        end
    end

    // Edge history, mask register and pending latch; a new edge beats an ack-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q   <= '0;
            mask    <= '0;
            pending <= '0;
        end else begin
            src_q   <= src;
            pending <= (pending & ~ack_clr) | edge_det;
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

`ifdef IRQ_OVERRUN_EN
    // Sticky overrun: an edge lands on a bit that is still pending after this cycle's clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= '0;
        end else begin
            overrun <= (overrun & ~(mask_we ? ~mask_wdata : '0))
                     | (edge_det & pending & ~ack_clr);
        end
    end
`else
    assign overrun = '0;
`endif

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Randomised bench for timer_irq_ctrl with a behavioural reference model and scoreboard.
module tb_timer_irq_ctrl;

    localparam int NSRC   = 4;
    localparam int VW     = 2;
    localparam int NCYC   = 3000;

    logic            clk;
    logic            reset;
    logic [NSRC-1:0] src;
    logic            mask_we;
    logic [NSRC-1:0] mask_wdata;
    logic            ack;
    logic            eoi;
    logic            irq;
    logic [VW-1:0]   vector;
    logic [NSRC-1:0] pending;
    logic            in_service;
    logic [NSRC-1:0] overrun;

    timer_irq_ctrl #(.NSRC(NSRC), .VW(VW)) dut (
        .clk        (clk),
        .reset      (reset),
        .src        (src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack        (ack),
        .eoi        (eoi),
        .irq        (irq),
        .vector     (vector),
        .pending    (pending),
        .in_service (in_service),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            irq;
        logic [VW-1:0]   vector;
        logic [NSRC-1:0] pending;
        logic            in_service;
        logic [NSRC-1:0] overrun;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   n_irq      = 0;
    int   n_ack      = 0;

    // Reference model: per-source event flags and a "what is the CPU doing" view.
    bit m_prev [NSRC];
    bit m_pend [NSRC];
    bit m_en   [NSRC];
    bit m_ovr  [NSRC];
    bit m_requesting;
    bit m_servicing;
    int m_cur;

    function automatic void model_reset();
        for (int i = 0; i < NSRC; i++) begin
            m_prev[i] = 0;
            m_pend[i] = 0;
            m_en[i]   = 0;
            m_ovr[i]  = 0;
        end
        m_requesting = 0;
        m_servicing  = 0;
        m_cur        = 0;
    endfunction

    // One clock edge of the specified behaviour, using the inputs held during the cycle.
    function automatic void model_step();
        bit rose [NSRC];
        bit old_pend [NSRC];
        bit old_en [NSRC];
        int taken;
        taken = (m_requesting && ack) ? m_cur : -1;
        for (int i = 0; i < NSRC; i++) begin
            rose[i]     = src[i] && !m_prev[i];
            old_pend[i] = m_pend[i];
            old_en[i]   = m_en[i];
        end
        for (int i = 0; i < NSRC; i++) begin
            if (mask_we && !mask_wdata[i]) m_ovr[i] = 0;
            if (rose[i] && old_pend[i] && (taken != i)) m_ovr[i] = 1;
            if (taken == i) m_pend[i] = 0;
            if (rose[i]) m_pend[i] = 1;
            if (mask_we) m_en[i] = mask_wdata[i];
            m_prev[i] = src[i];
        end
        if (m_requesting) begin
            if (ack) begin
                m_requesting = 0;
                m_servicing  = 1;
                n_ack++;
            end
        end else if (m_servicing) begin
            if (eoi) m_servicing = 0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (old_pend[i] && old_en[i]) begin
                    m_requesting = 1;
                    m_cur        = i;
                    n_irq++;
                    break;
                end
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.irq        = m_requesting;
        e.in_service = m_servicing;
        e.vector     = VW'(m_cur);
        for (int i = 0; i < NSRC; i++) begin
            e.pending[i] = m_pend[i];
`ifdef IRQ_OVERRUN_EN
            e.overrun[i] = m_ovr[i];
`else
            e.overrun[i] = 1'b0;
`endif
        end
        return e;
    endfunction

    task automatic drive_random();
        for (int i = 0; i < NSRC; i++) begin
            if ($urandom_range(3) == 0) src[i] = ~src[i];
        end
        mask_we    = ($urandom_range(11) == 0);
        mask_wdata = NSRC'($urandom);
        ack        = ($urandom_range(2) == 0);
        eoi        = ($urandom_range(2) == 0);
    endtask

    // Monitor: every falling edge the DUT presents a fresh state; compare it to the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                vectors++;
                if (irq !== e.irq) begin
                    miscompares++;
                    $display("FAIL irq @%0t: got %b want %b", $time, irq, e.irq);
                end
                if (in_service !== e.in_service) begin
                    miscompares++;
                    $display("FAIL in_service @%0t: got %b want %b", $time, in_service, e.in_service);
                end
                if (vector !== e.vector) begin
                    miscompares++;
                    $display("FAIL vector @%0t: got %0d want %0d", $time, vector, e.vector);
                end
                if (pending !== e.pending) begin
                    miscompares++;
                    $display("FAIL pending @%0t: got %b want %b", $time, pending, e.pending);
                end
                if (overrun !== e.overrun) begin
                    miscompares++;
                    $display("FAIL overrun @%0t: got %b want %b", $time, overrun, e.overrun);
                end
            end
        end
    end

    // Driver: stimulus plus model update at each rising edge; occasional async reset mid-cycle.
    initial begin
        bit do_rst;
        reset      = 1'b1;
        src        = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        ack        = 1'b0;
        eoi        = 1'b0;
        model_reset();
        q.push_back(model_out());
        @(negedge clk);
        #2 reset = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            do_rst = ($urandom_range(99) == 0);
            if (do_rst) model_reset();
            else        model_step();
            q.push_back(model_out());
            #1 drive_random();
            if (do_rst) begin
                // Reset lands between edges; outputs must already be clear at the next falling edge.
                #1 reset = 1'b1;
                #5 reset = 1'b0;
            end
        end
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        if (n_irq < 20 || n_ack < 20) begin
            miscompares++;
            $display("FAIL activity: %0d irqs %0d acks, want >= 20 each", n_irq, n_ack);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
